// File: rtl/ram128_arb_pkg.sv
// Shared types and helpers for the 128x32 SRAM arbiter / read-modify-write sequencer.
package ram128_arb_pkg;

    localparam int AW_DEF     = 7;
    localparam int WSIZE_DEF  = 4;
    localparam int DW_DEF     = WSIZE_DEF * 8;
    localparam int MAX_WSIZE  = 16;
    localparam int MAX_DW     = MAX_WSIZE * 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RMW_WAIT = 2'd2,
        RMW_WR   = 2'd3
    } state_t;

    // Callers zero-extend to MAX_DW and truncate the result back to their word width.
    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0]    wdata,
        input logic [MAX_DW-1:0]    rdata,
        input logic [MAX_WSIZE-1:0] be
    );
        logic [MAX_DW-1:0] res;
        for (int k = 0; k < MAX_WSIZE; k++) begin
            res[k*8 +: 8] = be[k] ? wdata[k*8 +: 8] : rdata[k*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ram128_rr_arb2.sv
// Two-way grant logic: round-robin by default, fixed priority (requester 0) when
// RAM128_ARB_FIXED_PRIO_EN is defined.
module ram128_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic       grant,
    output logic       grant_valid
);

    assign grant_valid = |valid;

`ifdef RAM128_ARB_FIXED_PRIO_EN
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, accept};
    assign grant = !valid[0];
`else
    logic last_grant;

    // A lone requester always wins; a tie goes to whoever did not win last.
    always_comb begin
        if (valid == 2'b11) grant = !last_grant;
        else                grant = valid[1];
    end

    always_ff @(posedge clk) begin
        if (rst)         last_grant <= 1'b1;
        else if (accept) last_grant <= grant;
    end
`endif

endmodule

// File: rtl/ram128_arb_rmw.sv
// Two-requester arbiter and sequencer for the 128x32 SRAM; partial-byte writes become
// read-modify-write sequences. Build option: RAM128_ARB_FIXED_PRIO_EN (fixed priority).
module ram128_arb_rmw
    import ram128_arb_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int WSIZE = WSIZE_DEF,
    localparam int DW   = WSIZE * 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0]           req_we,
    input  logic [2*WSIZE-1:0]   req_be,
    input  logic [2*AW-1:0]      req_addr,
    input  logic [2*DW-1:0]      req_wdata,
    output logic [1:0]           resp_valid,
    output logic [DW-1:0]        resp_rdata,
    output logic                 ram_en,
    output logic [WSIZE-1:0]     ram_we,
    output logic [AW-1:0]        ram_a,
    output logic [DW-1:0]        ram_di,
    input  logic [DW-1:0]        ram_do,
    output state_t               fsm_state
);

    state_t             state, state_n;
    logic               g, grant_valid, accept;
    logic               g_we;
    logic [WSIZE-1:0]   g_be;
    logic [AW-1:0]      g_addr;
    logic [DW-1:0]      g_wdata;
    logic [1:0]         g_onehot, lat_onehot;
    logic               lat_g;
    logic [AW-1:0]      lat_addr;
    logic [WSIZE-1:0]   lat_be;
    logic [DW-1:0]      lat_wdata, merged;

    ram128_rr_arb2 u_arb (
        .clk         (CLK),
        .rst         (RST),
        .valid       (req_valid),
        .accept      (accept),
        .grant       (g),
        .grant_valid (grant_valid)
    );

    assign g_we       = req_we[g];
    assign g_be       = req_be[int'(g)*WSIZE +: WSIZE];
    assign g_addr     = req_addr[int'(g)*AW +: AW];
    assign g_wdata    = req_wdata[int'(g)*DW +: DW];
    assign g_onehot   = g ? 2'b10 : 2'b01;
    assign lat_onehot = lat_g ? 2'b10 : 2'b01;
    assign fsm_state  = state;

    // Handshake: a request transfers on a cycle where req_valid[i] && req_ready[i];
    // ready is offered only in IDLE, only to the granted requester, never during reset.
    assign accept    = (state == IDLE) && !RST && grant_valid;
    assign req_ready = accept ? g_onehot : 2'b00;

    always_comb begin
        state_n = state;
        ram_en  = 1'b0;
        ram_we  = '0;
        ram_a   = lat_addr;
        ram_di  = merged;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    ram_a  = g_addr;
                    ram_di = g_wdata;
                    if (!g_we) begin
                        ram_en  = 1'b1;
                        state_n = RD_WAIT;
                    end else if (g_be == '1) begin
                        ram_en = 1'b1;
                        ram_we = '1;
                    end else if (g_be != '0) begin
                        ram_en  = 1'b1;
                        state_n = RMW_WAIT;
                    end
                end
            end
            RD_WAIT:  state_n = IDLE;
            RMW_WAIT: state_n = RMW_WR;
            RMW_WR: begin
                ram_en  = 1'b1;
                ram_we  = '1;
                state_n = IDLE;
            end
            default:  state_n = IDLE;
        endcase
        if (RST) begin
            ram_en = 1'b0;
            ram_we = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            resp_valid <= 2'b00;
            resp_rdata <= '0;
            lat_g      <= 1'b0;
            lat_addr   <= '0;
            lat_be     <= '0;
            lat_wdata  <= '0;
            merged     <= '0;
        end else begin
            state      <= state_n;
            resp_valid <= 2'b00;
            unique case (state)
                IDLE: begin
                    if (accept && g_we && (g_be == '1 || g_be == '0))
                        resp_valid <= g_onehot;
                end
                RD_WAIT: begin
                    resp_rdata <= ram_do;
                    resp_valid <= lat_onehot;
                end
                RMW_WAIT: merged <= DW'(byte_merge(MAX_DW'(lat_wdata), MAX_DW'(ram_do),
                                                   MAX_WSIZE'(lat_be)));
                RMW_WR:   resp_valid <= lat_onehot;
                default:  ;
            endcase
            if (accept) begin
                lat_g     <= g;
                lat_addr  <= g_addr;
                lat_be    <= g_be;
                lat_wdata <= g_wdata;
            end
        end
    end

endmodule

// File: tb/tb_ram128_arb_rmw.sv
// Directed self-checking bench for ram128_arb_rmw with a behavioural 128x32 SRAM model.
module tb_ram128_arb_rmw;
    import ram128_arb_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_we = '0;
    logic [7:0]  req_be = '0;
    logic [13:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [6:0]  ram_a;
    logic [31:0] ram_di;
    logic [31:0] ram_do = '0;
    state_t      fsm_state;

    int errors = 0;
    int checks = 0;
    int en_cnt = 0, wf_cnt = 0, wf_rmw_cnt = 0;
    int r0_cnt = 0, r1_cnt = 0;

    logic [31:0] mem [128];

    ram128_arb_rmw dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
        .ram_do(ram_do), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // SRAM model: full-word write when all byte enables set, registered read otherwise
    always @(posedge CLK) begin
        if (ram_en) begin
            if (ram_we == 4'hF) mem[ram_a] <= ram_di;
            else if (ram_we == 4'h0) ram_do <= mem[ram_a];
        end
    end

    always @(posedge CLK) begin
        if (ram_en) en_cnt++;
        if (ram_en && ram_we == 4'hF) begin
            wf_cnt++;
            if (fsm_state == RMW_WR) wf_rmw_cnt++;
        end
    end

    always @(negedge CLK) begin
        if (resp_valid[0]) r0_cnt++;
        if (resp_valid[1]) r1_cnt++;
    end

    // driver tasks
    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Leaves the caller at the falling edge of the cycle after the accept.
    task automatic issue(input int r, input logic we, input logic [3:0] be,
                         input logic [6:0] addr, input logic [31:0] wd);
        int waited = 0;
        @(negedge CLK);
        req_valid = '0;
        req_valid[r] = 1'b1;
        req_we[r] = we;
        req_be[r*4 +: 4] = be;
        req_addr[r*7 +: 7] = addr;
        req_wdata[r*32 +: 32] = wd;
        #1;
        while (!req_ready[r] && waited < 10) begin
            @(negedge CLK);
            #1;
            waited++;
        end
        checks++;
        if (!req_ready[r]) begin
            errors++;
            $display("FAIL issue_ready: req_ready=%b, required bit %0d set", req_ready, r);
        end
        @(posedge CLK);
        #1;
        req_valid = '0;
        @(negedge CLK);
    endtask

    task automatic wait_resp(input int r, output int lat);
        lat = 1;
        while (!resp_valid[r] && lat < 8) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic read_word(input int r, input logic [6:0] addr,
                             output logic [31:0] data, output int lat);
        issue(r, 1'b0, 4'h0, addr, 32'h0);
        wait_resp(r, lat);
        data = resp_rdata;
    endtask

    // scenarios
    task automatic test_reset();
        RST = 1'b1;
        req_valid = 2'b11;
        req_we = 2'b00;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", req_ready); end
        checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rst_ram_en: got %b want 0", ram_en); end
        checks++; if (ram_we !== 4'h0) begin errors++; $display("FAIL rst_ram_we: got %h want 0", ram_we); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rst_resp_valid: got %b want 00", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
        checks++; if (fsm_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want IDLE", fsm_state); end
        req_valid = 2'b00;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_full_write_read();
        int lat;
        logic [31:0] d;
        issue(0, 1'b1, 4'hF, 7'h05, 32'hDEADBEEF);
        wait_resp(0, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL fw_resp_latency: got %0d want 1", lat); end
        read_word(0, 7'h05, d, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_resp_latency: got %0d want 2", lat); end
        checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", d); end
        @(negedge CLK);
        checks++; if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold: got %h want deadbeef", resp_rdata); end
    endtask

    task automatic test_partial_rmw();
        int lat;
        logic [31:0] d;
        mem[7'h10] = 32'h11223344;
        mem[7'h11] = 32'h11223344;
        @(negedge CLK);
        wf_cnt = 0;
        wf_rmw_cnt = 0;
        issue(1, 1'b1, 4'b0101, 7'h10, 32'hAABBCCDD);
        wait_resp(1, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL rmw_resp_latency: got %0d want 3", lat); end
        checks++; if (wf_cnt !== 1) begin errors++; $display("FAIL rmw_write_cycles: got %0d want 1", wf_cnt); end
        checks++; if (wf_rmw_cnt !== 1) begin errors++; $display("FAIL rmw_write_in_rmw_wr: got %0d want 1", wf_rmw_cnt); end
        checks++; if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rmw_rdata_unchanged: got %h want deadbeef", resp_rdata); end
        read_word(1, 7'h10, d, lat);
        checks++; if (d !== 32'h11BB33DD) begin errors++; $display("FAIL rmw_merge_0101: got %h want 11bb33dd", d); end
        issue(0, 1'b1, 4'b0010, 7'h11, 32'hAABBCCDD);
        wait_resp(0, lat);
        read_word(0, 7'h11, d, lat);
        checks++; if (d !== 32'h1122CC44) begin errors++; $display("FAIL rmw_merge_0010: got %h want 1122cc44", d); end
    endtask

    task automatic test_contention();
        int n = 0;
        int cyc = 0;
        logic [1:0] rdy, exp_rdy;
        do_reset();
        mem[7'h40] = 32'h0000AAAA;
        mem[7'h41] = 32'h0000BBBB;
        r0_cnt = 0;
        r1_cnt = 0;
        @(negedge CLK);
        req_we = 2'b00;
        req_addr = {7'h41, 7'h40};
        req_valid = 2'b11;
        while (n < 8 && cyc < 60) begin
            #1;
            rdy = req_ready;
            if (rdy != 2'b00) begin
`ifdef RAM128_ARB_FIXED_PRIO_EN
                exp_rdy = 2'b01;
`else
                exp_rdy = (n % 2 == 0) ? 2'b01 : 2'b10;
`endif
                checks++;
                if (rdy !== exp_rdy) begin
                    errors++;
                    $display("FAIL contention_grant_%0d: ready=%b want %b", n, rdy, exp_rdy);
                end
                n++;
            end
            @(negedge CLK);
            cyc++;
        end
        req_valid = 2'b00;
        checks++; if (n !== 8) begin errors++; $display("FAIL contention_accepts: got %0d want 8", n); end
        repeat (4) @(negedge CLK);
`ifdef RAM128_ARB_FIXED_PRIO_EN
        checks++; if (r0_cnt !== 8 || r1_cnt !== 0) begin errors++; $display("FAIL contention_resps: got %0d/%0d want 8/0", r0_cnt, r1_cnt); end
`else
        checks++; if (r0_cnt !== 4 || r1_cnt !== 4) begin errors++; $display("FAIL contention_resps: got %0d/%0d want 4/4", r0_cnt, r1_cnt); end
`endif
    endtask

    task automatic test_be0_write();
        int lat;
        logic [31:0] d;
        mem[7'h20] = 32'h12345678;
        @(negedge CLK);
        en_cnt = 0;
        issue(0, 1'b1, 4'h0, 7'h20, 32'hFFFFFFFF);
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL be0_resp: got %b want 01", resp_valid); end
        checks++; if (en_cnt !== 0) begin errors++; $display("FAIL be0_ram_en: got %0d cycles want 0", en_cnt); end
        read_word(0, 7'h20, d, lat);
        checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL be0_word: got %h want 12345678", d); end
    endtask

    task automatic test_reset_rmw();
        mem[7'h30] = 32'hCAFEF00D;
        @(negedge CLK);
        r0_cnt = 0;
        r1_cnt = 0;
        wf_cnt = 0;
        issue(1, 1'b1, 4'b0011, 7'h30, 32'h12345678);
        checks++; if (fsm_state !== RMW_WAIT) begin errors++; $display("FAIL rrmw_state: got %0d want RMW_WAIT", fsm_state); end
        RST = 1'b1;
        @(negedge CLK);
        #1;
        checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rrmw_ram_en_in_rst: got %b want 0", ram_en); end
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (r0_cnt !== 0 || r1_cnt !== 0) begin errors++; $display("FAIL rrmw_no_resp: got %0d/%0d want 0/0", r0_cnt, r1_cnt); end
        checks++; if (wf_cnt !== 0) begin errors++; $display("FAIL rrmw_no_write: got %0d want 0", wf_cnt); end
        checks++; if (mem[7'h30] !== 32'hCAFEF00D) begin errors++; $display("FAIL rrmw_word: got %h want cafef00d", mem[7'h30]); end
        req_we = 2'b00;
        req_addr = {7'h30, 7'h30};
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rrmw_next_grant: got %b want 01", req_ready); end
        @(posedge CLK);
        #1;
        req_valid = 2'b00;
        repeat (3) @(negedge CLK);
        checks++; if (resp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rrmw_readback: got %h want cafef00d", resp_rdata); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] d;
        @(negedge CLK);
        en_cnt = 0;
        r0_cnt = 0;
        req_we = 2'b01;
        req_be = 8'h0F;
        req_addr = 14'd0;
        req_wdata = {32'h0, 32'hB0B0_0000};
        req_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL b2b_ready_%0d: got %b want 01", i, req_ready); end
            @(posedge CLK);
            #1;
            if (i < 3) begin
                req_addr = 14'(i + 1);
                req_wdata = {32'h0, 32'hB0B0_0000 + 32'(i + 1)};
            end else begin
                req_valid = 2'b00;
            end
            @(negedge CLK);
            checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL b2b_resp_%0d: got %b want 01", i, resp_valid); end
        end
        checks++; if (en_cnt !== 4) begin errors++; $display("FAIL b2b_ram_en_cycles: got %0d want 4", en_cnt); end
        for (int i = 0; i < 4; i++) begin
            read_word(0, 7'(i), d, lat);
            checks++; if (d !== 32'hB0B0_0000 + 32'(i)) begin errors++; $display("FAIL b2b_readback_%0d: got %h want %h", i, d, 32'hB0B0_0000 + 32'(i)); end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        test_reset();
        test_full_write_read();
        test_partial_rmw();
        test_contention();
        test_be0_write();
        test_reset_rmw();
        test_back_to_back();
        repeat (2) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
